// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the yCPU pipeline hazard/flush controller.
// Stage indices map stall mask bits to pipeline registers.
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StFlush
    } ctrl_state_e;

    localparam int unsigned STG_PC  = 0;
    localparam int unsigned STG_IF  = 1;
    localparam int unsigned STG_ID  = 2;
    localparam int unsigned STG_EX  = 3;
    localparam int unsigned STG_MEM = 4;
    localparam int unsigned STG_WB  = 5;

    // Wide enough for FLUSH_CYCLES up to 15.
    localparam int unsigned FLUSH_CNT_W = 4;

endpackage

// File: rtl/stall_mask_enc.sv
// Highest-set-bit to thermometer encoder: every stage at or below the
// highest requesting stage holds.
module stall_mask_enc #(
    parameter int unsigned NUM_STAGES = 6
) (
    input  logic [NUM_STAGES-1:0] req_i,
    output logic [NUM_STAGES-1:0] mask_o
);

    logic acc;

    // Running OR from the top stage down yields the thermometer directly.
    always_comb begin
        mask_o = '0;
        acc    = 1'b0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            acc       = acc | req_i[i];
            mask_o[i] = acc;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/flush controller: stall mask, exception/ERET flush with PC redirect,
// saturating stall counter. Optional watchdog output when PIPE_STALL_WATCHDOG_EN is defined.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STAGES   = 6,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned WDOG_LIMIT   = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] stallreq_i,
    input  logic                  excp_valid_i,
    input  logic [ADDR_W-1:0]     excp_vector_i,
    input  logic                  eret_i,
    input  logic [ADDR_W-1:0]     epc_i,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic                  flush_o,
    output logic                  redirect_o,
    output logic [ADDR_W-1:0]     new_pc_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
`ifdef PIPE_STALL_WATCHDOG_EN
    output logic                  wdog_o,
`endif
    output logic                  busy_o
);

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15 || WDOG_LIMIT < 1) begin : g_param_err
        $error("pipe_hazard_ctrl: FLUSH_CYCLES must be 1..15 and WDOG_LIMIT >= 1");
    end

    ctrl_state_e            state_q, state_d;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [ADDR_W-1:0]      new_pc_q, new_pc_d;
    logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;
    logic [NUM_STAGES-1:0]  mask;

    stall_mask_enc #(
        .NUM_STAGES(NUM_STAGES)
    ) u_mask_enc (
        .req_i (stallreq_i),
        .mask_o(mask)
    );

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        new_pc_d    = new_pc_q;
        stall_o     = '0;
        flush_o     = 1'b0;
        redirect_o  = 1'b0;
        busy_o      = 1'b0;

        unique case (state_q)
            StIdle: begin
                stall_o = mask;
                // Exception outranks ERET when both arrive together.
                if (excp_valid_i) begin
                    state_d     = StFlush;
                    flush_cnt_d = '0;
                    new_pc_d    = excp_vector_i;
                end else if (eret_i) begin
                    state_d     = StFlush;
                    flush_cnt_d = '0;
                    new_pc_d    = epc_i;
                end
            end
            StFlush: begin
                flush_o    = 1'b1;
                busy_o     = 1'b1;
                redirect_o = (flush_cnt_q == '0);
                if (flush_cnt_q == FLUSH_CNT_W'(FLUSH_CYCLES - 1)) begin
                    state_d = StIdle;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        stall_cnt_d = stall_cnt_q;
        if (stall_o[STG_PC] && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            flush_cnt_q <= '0;
            new_pc_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            new_pc_q    <= new_pc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign new_pc_o    = new_pc_q;
    assign stall_cnt_o = stall_cnt_q;

`ifdef PIPE_STALL_WATCHDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_LIMIT + 1);

    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic              wdog_q, wdog_d;

    // Consecutive-stall run length, parked at the limit once reached.
    always_comb begin
        wdog_cnt_d = '0;
        if (stall_o[STG_PC]) begin
            wdog_cnt_d = (wdog_cnt_q == WDOG_W'(WDOG_LIMIT)) ? wdog_cnt_q : wdog_cnt_q + 1'b1;
        end
        wdog_d = wdog_q | (wdog_cnt_d == WDOG_W'(WDOG_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt_q <= '0;
            wdog_q     <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_q     <= wdog_d;
        end
    end

    assign wdog_o = wdog_q;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised pipeline hazard/flush controller for the yCPU in-order core. Takes per-stage stall requests and turns them into a thermometer stall mask over NUM_STAGES pipeline registers. Adds exception/ERET flush sequencing with a redirect PC and a saturating stall-cycle performance counter. Sits beside the pipeline; drives every pipeline-register stall input and the PC-register redirect.

Parameters:
NUM_STAGES, 6, number of stall-controlled stages; bit 0 = PC register, bit NUM_STAGES-1 = last register (WB)
ADDR_W, 32, width of PC/vector addresses
FLUSH_CYCLES, 1, cycles flush_o stays high per flush event (1..15)
CNT_W, 32, width of stall-cycle counter
WDOG_LIMIT, 1024, consecutive-stall limit for the optional watchdog

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
stallreq_i  in  NUM_STAGES  bit k = stage k requests that stages 0..k hold
excp_valid_i  in  1  exception detected (commit stage), one-cycle pulse
excp_vector_i  in  ADDR_W  handler address, valid with excp_valid_i
eret_i  in  1  exception-return request, one-cycle pulse
epc_i  in  ADDR_W  return address, valid with eret_i
stall_o  out  NUM_STAGES  per-stage hold; 1 = stage register holds
flush_o  out  1  clear all pipeline registers
redirect_o  out  1  PC loads new_pc_o this cycle
new_pc_o  out  ADDR_W  redirect target
stall_cnt_o  out  CNT_W  saturating count of cycles with stall_o[0]=1
busy_o  out  1  high while in FLUSH state

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; stall_o=0, flush_o=0, redirect_o=0, new_pc_o=0, stall_cnt_o=0, busy_o=0. Asserting rst during FLUSH aborts the flush immediately.
- Stall mask (combinational from stallreq_i, IDLE only): k = highest set bit of stallreq_i; stall_o[i]=1 for i<=k, else 0. No request -> all zero. E.g. NUM_STAGES=6, req bit 3 -> 6'b001111; bit 2 -> 6'b000111; bits 2 and 3 -> 6'b001111.
- FSM states IDLE, FLUSH.
  - IDLE: excp_valid_i=1 at posedge -> FLUSH; new_pc_o<=excp_vector_i. Else eret_i=1 -> FLUSH; new_pc_o<=epc_i. Both set same cycle: exception wins, eret dropped.
  - FLUSH: flush_o=1, busy_o=1, stall_o forced all-zero (flush overrides stall), redirect_o=1 only in the first FLUSH cycle. Internal counter runs FLUSH_CYCLES cycles, then -> IDLE. excp_valid_i/eret_i ignored while in FLUSH.
- Latency: request at edge N -> flush_o/redirect_o high during cycle N+1 (registered outputs). new_pc_o holds its value until the next event.
- stall_cnt_o: +1 at each posedge where stall_o[0]=1; saturates at all-ones, no wrap.

Optional Feature:
Macro PIPE_STALL_WATCHDOG_EN. When defined: extra output wdog_o (1 bit); internal counter of consecutive cycles with stall_o[0]=1, cleared on any cycle without it. When the count reaches WDOG_LIMIT, wdog_o sets and stays sticky until rst. When undefined: no wdog_o port, no counter logic.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - FSM state typedef (IDLE, FLUSH).
  - Stage index constants STG_PC, STG_IF, STG_ID, STG_EX, STG_MEM, STG_WB.
- Sub-module stall_mask_enc: combinational highest-set-bit to thermometer-mask encoder, parametrised by NUM_STAGES.

Test Plan:
- Reset, then stallreq_i=0 -> stall_o=0, flush_o=0, stall_cnt_o=0.
- stallreq_i=6'b000100 -> stall_o=6'b000111. Then 6'b001100 -> 6'b001111. Held 5 cycles -> stall_cnt_o=5.
- excp_valid_i pulse, vector 0x0000_0020, FLUSH_CYCLES=2 -> next cycle flush_o=1, redirect_o=1, new_pc_o=0x20. Following cycle flush_o=1, redirect_o=0. Then IDLE.
- excp_valid_i and eret_i same cycle (epc 0x400) -> new_pc_o=0x20. Only one flush sequence.
- stallreq_i=6'b001000 during FLUSH -> stall_o=0. A second excp_valid_i inside FLUSH is ignored. rst mid-FLUSH -> all outputs 0 next cycle.
- With PIPE_STALL_WATCHDOG_EN and WDOG_LIMIT=8: stall held 8 cycles -> wdog_o=1, stays 1 after stall drops until rst.
